// File: rtl/poly_pkg.sv
// Shared widths, FSM state type and rotate helpers for the polynomial
// normalize/unshift path.
package poly_pkg;

    localparam int POLY_W = 4;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ROTATE = 1'b1
    } state_t;

    function automatic logic [POLY_W-1:0] rotl1(input logic [POLY_W-1:0] v);
        return {v[POLY_W-2:0], v[POLY_W-1]};
    endfunction

    function automatic logic [POLY_W-1:0] rotl_n(
        input logic [POLY_W-1:0] v,
        input logic [CNT_W-1:0]  n
    );
        logic [POLY_W-1:0] r;
        r = v;
        for (int i = 0; i < (1 << CNT_W); i++) begin
            if (i < int'(n)) begin
                r = rotl1(r);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/poly_unshifter.sv
// Rebuilds a polynomial from its normalized top bits and rotate count.
// Define POLY_UNSHIFTER_FAST_EN for a single-cycle barrel-rotate build.
module poly_unshifter
    import poly_pkg::*;
#(
    parameter int STICKY_OVR = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] select_line,
    input  logic [CNT_W-1:0] i_shifter_count,
    input  logic             polynomial_zero,
    input  logic             select_line_vld,
    output logic             in_rdy,
    output logic [POLY_W-1:0] polynomial,
    output logic             polynomial_vld,
    output logic             fmt_err,
    output logic             ovr_err
);

    logic [POLY_W-1:0] base;
    logic              top_nz;
    logic              fmt_in;

    logic [POLY_W-1:0] poly_d, poly_q;
    logic              vld_d, vld_q;
    logic              fmt_d, fmt_q;

    assign base = {select_line, 1'b1};

    // Bits that would have been rotated out of the low end must be zero.
    always_comb begin
        top_nz = 1'b0;
        unique case (i_shifter_count)
            2'd0: top_nz = 1'b0;
            2'd1: top_nz = select_line[2];
            2'd2: top_nz = |select_line[2:1];
            2'd3: top_nz = |select_line;
            default: top_nz = 1'b0;
        endcase
        fmt_in = polynomial_zero ? (select_line != '0) : top_nz;
    end

    assign polynomial     = poly_q;
    assign polynomial_vld = vld_q;
    assign fmt_err        = fmt_q;

`ifdef POLY_UNSHIFTER_FAST_EN

    always_comb begin
        poly_d = poly_q;
        vld_d  = 1'b0;
        fmt_d  = 1'b0;
        if (select_line_vld) begin
            poly_d = polynomial_zero ? '0 : rotl_n(base, i_shifter_count);
            vld_d  = 1'b1;
            fmt_d  = fmt_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            poly_q <= '0;
            vld_q  <= 1'b0;
            fmt_q  <= 1'b0;
        end else begin
            poly_q <= poly_d;
            vld_q  <= vld_d;
            fmt_q  <= fmt_d;
        end
    end

    assign in_rdy  = 1'b1;
    assign ovr_err = 1'b0;

`else

    state_t            state_d, state_q;
    logic [POLY_W-1:0] latch_d, latch_q;
    logic [CNT_W-1:0]  rem_d, rem_q;
    logic              pend_d, pend_q;
    logic              ovr_d, ovr_q;

    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        rem_d   = rem_q;
        pend_d  = pend_q;
        poly_d  = poly_q;
        vld_d   = 1'b0;
        fmt_d   = 1'b0;
        ovr_d   = (STICKY_OVR != 0) ? ovr_q : 1'b0;
        unique case (state_q)
            IDLE: begin
                if (select_line_vld) begin
                    if (polynomial_zero) begin
                        poly_d = '0;
                        vld_d  = 1'b1;
                        fmt_d  = fmt_in;
                    end else if (i_shifter_count == '0) begin
                        poly_d = base;
                        vld_d  = 1'b1;
                        fmt_d  = fmt_in;
                    end else begin
                        latch_d = rotl1(base);
                        rem_d   = i_shifter_count - 2'd1;
                        pend_d  = fmt_in;
                        state_d = ROTATE;
                    end
                end
            end
            ROTATE: begin
                // Busy: any new request is lost, including on the last cycle.
                if (select_line_vld) begin
                    ovr_d = 1'b1;
                end
                if (rem_q == '0) begin
                    poly_d  = latch_q;
                    vld_d   = 1'b1;
                    fmt_d   = pend_q;
                    state_d = IDLE;
                end else begin
                    latch_d = rotl1(latch_q);
                    rem_d   = rem_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            latch_q <= '0;
            rem_q   <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            poly_q  <= '0;
            vld_q   <= 1'b0;
            fmt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            poly_q  <= poly_d;
            vld_q   <= vld_d;
            fmt_q   <= fmt_d;
        end
    end

    assign in_rdy  = (state_q == IDLE);
    assign ovr_err = ovr_q;

`endif

endmodule

// File: tb/tb_poly_unshifter.sv
// Directed bench for poly_unshifter: results, latency, errors, overrun, reset.
module tb_poly_unshifter;

`ifdef POLY_UNSHIFTER_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int STICKY = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] select_line;
    logic [1:0] i_shifter_count;
    logic       polynomial_zero;
    logic       select_line_vld;
    logic       in_rdy;
    logic [3:0] polynomial;
    logic       polynomial_vld;
    logic       fmt_err;
    logic       ovr_err;

    int nvec = 0;
    int nbad = 0;

    poly_unshifter #(.STICKY_OVR(STICKY)) dut (
        .clk             (clk),
        .reset           (reset),
        .select_line     (select_line),
        .i_shifter_count (i_shifter_count),
        .polynomial_zero (polynomial_zero),
        .select_line_vld (select_line_vld),
        .in_rdy          (in_rdy),
        .polynomial      (polynomial),
        .polynomial_vld  (polynomial_vld),
        .fmt_err         (fmt_err),
        .ovr_err         (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input string tag, input logic [2:0] sel,
                         input logic [1:0] k, input logic z,
                         input logic [3:0] exp_p, input logic exp_f,
                         input int lat_slow);
        int lat;
        lat = FAST ? 1 : lat_slow;
        @(negedge clk);
        chk({tag, ".rdy"}, {3'b0, in_rdy}, 4'd1);
        select_line     = sel;
        i_shifter_count = k;
        polynomial_zero = z;
        select_line_vld = 1'b1;
        tick();
        select_line_vld = 1'b0;
        for (int n = 1; n < lat; n++) begin
            chk({tag, ".vld_early"}, {3'b0, polynomial_vld}, 4'd0);
            chk({tag, ".rdy_busy"}, {3'b0, in_rdy}, 4'd0);
            tick();
        end
        chk({tag, ".vld"}, {3'b0, polynomial_vld}, 4'd1);
        chk({tag, ".poly"}, polynomial, exp_p);
        chk({tag, ".fmt"}, {3'b0, fmt_err}, {3'b0, exp_f});
        tick();
        chk({tag, ".vld_drop"}, {3'b0, polynomial_vld}, 4'd0);
        chk({tag, ".fmt_drop"}, {3'b0, fmt_err}, 4'd0);
        chk({tag, ".hold"}, polynomial, exp_p);
    endtask

    initial begin
        reset           = 1'b1;
        select_line     = '0;
        i_shifter_count = '0;
        polynomial_zero = 1'b0;
        select_line_vld = 1'b0;
        tick();
        tick();
        chk("rst.poly", polynomial, 4'd0);
        chk("rst.vld", {3'b0, polynomial_vld}, 4'd0);
        chk("rst.fmt", {3'b0, fmt_err}, 4'd0);
        chk("rst.ovr", {3'b0, ovr_err}, 4'd0);
        chk("rst.rdy", {3'b0, in_rdy}, 4'd1);
        @(negedge clk);
        reset = 1'b0;

        apply("k0_101", 3'b101, 2'd0, 1'b0, 4'b1011, 1'b0, 1);
        apply("k3_000", 3'b000, 2'd3, 1'b0, 4'b1000, 1'b0, 4);
        apply("k2_001", 3'b001, 2'd2, 1'b0, 4'b1100, 1'b0, 3);
        apply("k1_010", 3'b010, 2'd1, 1'b0, 4'b1010, 1'b0, 2);
        apply("z_000", 3'b000, 2'd0, 1'b1, 4'b0000, 1'b0, 1);
        apply("k0_011", 3'b011, 2'd0, 1'b0, 4'b0111, 1'b0, 1);
        apply("z_011", 3'b011, 2'd0, 1'b1, 4'b0000, 1'b1, 1);
        apply("k2_100", 3'b100, 2'd2, 1'b0, 4'b0110, 1'b1, 3);
        apply("k1_110", 3'b110, 2'd1, 1'b0, 4'b1011, 1'b1, 2);
        apply("z_k2", 3'b000, 2'd2, 1'b1, 4'b0000, 1'b0, 1);
        apply("k3_001", 3'b001, 2'd3, 1'b0, 4'b1001, 1'b1, 4);
        chk("ovr.none", {3'b0, ovr_err}, 4'd0);

        if (!FAST) begin
            // Second request one cycle after a k=3 accept is dropped.
            @(negedge clk);
            select_line     = 3'b000;
            i_shifter_count = 2'd3;
            polynomial_zero = 1'b0;
            select_line_vld = 1'b1;
            tick();
            @(negedge clk);
            select_line     = 3'b111;
            i_shifter_count = 2'd0;
            tick();
            select_line_vld = 1'b0;
            chk("ovr.set", {3'b0, ovr_err}, 4'd1);
            chk("ovr.vld0", {3'b0, polynomial_vld}, 4'd0);
            tick();
            chk("ovr.vld1", {3'b0, polynomial_vld}, 4'd0);
            chk("ovr.hold1", {3'b0, ovr_err}, STICKY ? 4'd1 : 4'd0);
            tick();
            chk("ovr.res_vld", {3'b0, polynomial_vld}, 4'd1);
            chk("ovr.res", polynomial, 4'b1000);
            tick();
            chk("ovr.no_2nd", {3'b0, polynomial_vld}, 4'd0);
            chk("ovr.res_hold", polynomial, 4'b1000);
            chk("ovr.hold2", {3'b0, ovr_err}, STICKY ? 4'd1 : 4'd0);

            // Reset on the second cycle of a k=3 rotate aborts it.
            @(negedge clk);
            select_line     = 3'b000;
            i_shifter_count = 2'd3;
            select_line_vld = 1'b1;
            tick();
            select_line_vld = 1'b0;
            tick();
            @(negedge clk);
            reset = 1'b1;
            tick();
            chk("abort.vld", {3'b0, polynomial_vld}, 4'd0);
            chk("abort.poly", polynomial, 4'd0);
            chk("abort.rdy", {3'b0, in_rdy}, 4'd1);
            chk("abort.ovr", {3'b0, ovr_err}, 4'd0);
            @(negedge clk);
            reset = 1'b0;
            for (int n = 0; n < 5; n++) begin
                tick();
                chk("abort.quiet", {3'b0, polynomial_vld}, 4'd0);
            end
            chk("abort.poly2", polynomial, 4'd0);
        end

        apply("post_k1", 3'b011, 2'd1, 1'b0, 4'b1110, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
